pio_in_edge_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO slave for the Nios II system: WIDTH-bit async input bus,

---
 rtl/pio_in_pkg.sv | 16 +
 rtl/pio_in_debounce.sv | 46 ++++
 rtl/pio_in_edge_irq.sv | 129 ++++++++++++
 tb/tb_pio_in_edge_irq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_in_pkg.sv
// pio_in_pkg: shared constants for the Avalon-MM edge-capturing input PIO.
//   Register word addresses and the EDGE_TYPE encodings used by pio_in_edge_irq.
package pio_in_pkg;

    // Register map (word addresses)
    localparam logic [1:0] ADDR_DATA = 2'd0;  // filtered input value, RO
    localparam logic [1:0] ADDR_RSVD = 2'd1;  // reads 0
    localparam logic [1:0] ADDR_MASK = 2'd2;  // IRQ mask, RW
    localparam logic [1:0] ADDR_EDGE = 2'd3;  // edge capture, write-1-to-clear

    // EDGE_TYPE encodings
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// pio_in_debounce: one-bit debounce filter.
//   The output follows the input only after the input has differed from the
//   output for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (output resets to 0)
//   din      in  synchronised input bit
//   dout     out filtered bit (registered)
module pio_in_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_d;

    always_comb begin
        cnt_d = '0;
        out_d = dout;
        if (din != dout) begin
            if (cnt_q == CNT_LAST) begin
                out_d = din;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            dout  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dout  <= out_d;
        end
    end

endmodule

// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO slave with per-bit edge capture and a
//   maskable level interrupt for the Nios II IRQ controller.
//   in_port is synchronised (SYNC_STAGES flops), optionally debounced, then edge
//   detected against a one-cycle-delayed copy. Captures are sticky until W1C.
//   Optional feature macro: PIO_IN_DEBOUNCE_EN (adds a pio_in_debounce per bit).
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   word address (0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAPTURE)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe, qualified by chipselect
//   writedata   in   write data
//   readdata    out  registered read data, loaded every cycle from the address mux
//   in_port     in   asynchronous external input
//   irq         out  level interrupt, |(edge_capture & irq_mask)
module pio_in_edge_irq
    import pio_in_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Edge detection stays off until the sync chain and prev flop have loaded
    // real input, so a pin held high through reset is not seen as a rising edge.
    localparam int unsigned   ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned   AW         = $clog2(ARM_CYCLES + 1);
    localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_CYCLES);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_out;
    logic [WIDTH-1:0]                  filt;
    logic [WIDTH-1:0]                  prev_q;
    logic [AW-1:0]                     arm_q, arm_d;
    logic                              armed;
    logic [WIDTH-1:0]                  rise, fall, edge_sel, edge_det;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  cap_q, cap_d;
    logic [WIDTH-1:0]                  w1c;
    logic                              wr_en;
    logic [31:0]                       rd_d;
    logic                              unused_writedata;

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        pio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (sync_out[i]),
            .dout    (filt[i])
        );
    end
`else
    assign filt = sync_out;
`endif

    assign armed = (arm_q == ARM_LAST);
    assign arm_d = armed ? arm_q : arm_q + AW'(1);

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;

    always_comb begin
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_sel = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_sel = rise | fall;
        end else begin
            edge_sel = rise;
        end
    end

    assign edge_det = armed ? edge_sel : '0;

    assign wr_en  = chipselect & ~write_n;
    assign mask_d = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
    assign w1c    = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    // OR-ing the new edge in after the clear makes a coincident edge win.
    assign cap_d  = (cap_q & ~w1c) | edge_det;

    assign irq = |(cap_q & mask_q);

    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA: rd_d[WIDTH-1:0] = filt;
            ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_d[WIDTH-1:0] = cap_q;
            default:   rd_d = '0;
        endcase
    end

    // Bits above WIDTH are ignored on write.
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev_q   <= '0;
            arm_q    <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            readdata <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q   <= filt;
            arm_q    <= arm_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            readdata <= rd_d;
        end
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: self-checking bench for pio_in_edge_irq.
//   Two instances share the bus: u_dut_rise (EDGE_TYPE=0) and u_dut_any (EDGE_TYPE=2).
//   Register reads push their expected value to a scoreboard; a negedge monitor pops
//   and compares once readdata has been loaded.
module tb_pio_in_edge_irq;

    localparam int unsigned SYNC = 2;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int unsigned DB = 16;
`else
    localparam int unsigned DB = 0;
`endif
    localparam int unsigned LAT_DATA = SYNC + DB;
    localparam int unsigned LAT_CAP  = LAT_DATA + 1;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_a, in_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    string       tag_q[$];
    logic [32:0] exp_q[$];   // bit 32 selects u_dut_any
    string       mon_tag;
    logic [32:0] mon_exp;
    logic        rd_req  = 1'b0;
    logic        rd_seen = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    pio_in_edge_irq #(
        .WIDTH(8), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)
    ) u_dut_rise (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_a),
        .in_port    (in_a),
        .irq        (irq_a)
    );

    pio_in_edge_irq #(
        .WIDTH(8), .SYNC_STAGES(SYNC), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)
    ) u_dut_any (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_b),
        .in_port    (in_b),
        .irq        (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Read issued now; readdata is loaded at the next posedge and checked at the negedge.
    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp,
                      input bit use_b);
        tag_q.push_back(tag);
        exp_q.push_back({use_b, exp});
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        rd_req     = 1'b1;
        @(posedge clk);
        #1;
        rd_req     = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        address    = a;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    always @(posedge clk) rd_seen <= rd_req;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", exp_q.size(), 1);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                check_eq(mon_tag, mon_exp[32] ? rd_b : rd_a, mon_exp[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_a       = 8'hFF;
        in_b       = 8'hFF;
        tick(3);
        check_eq("reset_rd_a", rd_a, 32'h0);
        check_eq("reset_irq_a", {31'b0, irq_a}, 32'h0);
        check_eq("reset_irq_b", {31'b0, irq_b}, 32'h0);

        // 1: input held high through reset
        reset_n = 1'b1;
        for (int i = 0; i < int'(LAT_DATA); i++) rd("t1_data_pre", 2'd0, 32'h0, 1'b0);
        rd("t1_data", 2'd0, 32'hFF, 1'b0);
        rd("t1_data_b", 2'd0, 32'hFF, 1'b1);
        tick(2);
        rd("t1_edge_a", 2'd3, (DB != 0) ? 32'hFF : 32'h0, 1'b0);
        rd("t1_edge_b", 2'd3, (DB != 0) ? 32'hFF : 32'h0, 1'b1);
        check_eq("t1_irq_a", {31'b0, irq_a}, 32'h0);
        if (DB != 0) wr(2'd3, 32'hFF);

        // 2: rising edge on bit0, masked in, then W1C
        in_a = 8'h00;
        tick(LAT_CAP + 2);
        rd("t2_fall_ignored", 2'd3, 32'h0, 1'b0);
        wr(2'd2, 32'h01);
        in_a = 8'h01;
        tick(LAT_CAP - 1);
        check_eq("t2_irq_early", {31'b0, irq_a}, 32'h0);
        tick(1);
        check_eq("t2_irq", {31'b0, irq_a}, 32'h1);
        rd("t2_edge", 2'd3, 32'h01, 1'b0);
        rd("t2_data", 2'd0, 32'h01, 1'b0);
        wr(2'd3, 32'h01);
        check_eq("t2_irq_clr", {31'b0, irq_a}, 32'h0);
        rd("t2_edge_clr", 2'd3, 32'h0, 1'b0);

        // 3: W1C lands on the same edge as a new capture
        in_a = 8'h00;
        tick(LAT_CAP + 2);
        in_a = 8'h01;
        tick(LAT_CAP - 1);
        wr(2'd3, 32'h01);
        check_eq("t3_irq_kept", {31'b0, irq_a}, 32'h1);
        rd("t3_edge_kept", 2'd3, 32'h01, 1'b0);
        wr(2'd3, 32'h01);
        check_eq("t3_irq_clr", {31'b0, irq_a}, 32'h0);

        // 4: capture while masked, unmask raises irq without clearing
        wr(2'd2, 32'h00);
        in_a = 8'h09;
        tick(LAT_CAP + 1);
        check_eq("t4_irq_masked", {31'b0, irq_a}, 32'h0);
        rd("t4_edge", 2'd3, 32'h08, 1'b0);
        wr(2'd2, 32'h08);
        check_eq("t4_irq_unmask", {31'b0, irq_a}, 32'h1);
        rd("t4_edge_kept", 2'd3, 32'h08, 1'b0);
        rd("t4_mask", 2'd2, 32'h08, 1'b0);
        rd("t4_rsvd", 2'd1, 32'h0, 1'b0);
        wr(2'd3, 32'h08);
        in_a = 8'h01;
        tick(LAT_CAP + 2);
        rd("t4_fall_ignored", 2'd3, 32'h0, 1'b0);
        check_eq("t4_irq_idle", {31'b0, irq_a}, 32'h0);

        // 5: any-edge instance, bit7 falls then rises
        in_b = 8'h7F;
        tick(LAT_CAP + 1);
        rd("t5_fall", 2'd3, 32'h80, 1'b1);
        check_eq("t5_irq_masked", {31'b0, irq_b}, 32'h0);
        wr(2'd3, 32'h80);
        rd("t5_clr", 2'd3, 32'h0, 1'b1);
        in_b = 8'hFF;
        tick(LAT_CAP + 1);
        rd("t5_rise", 2'd3, 32'h80, 1'b1);
        rd("t5_data", 2'd0, 32'hFF, 1'b1);
        wr(2'd2, 32'h80);
        check_eq("t5_irq", {31'b0, irq_b}, 32'h1);

`ifdef PIO_IN_DEBOUNCE_EN
        // 6: 5-cycle glitch is filtered; a long pulse appears 16 cycles after sync
        wr(2'd3, 32'hFF);
        in_a = 8'h03;
        tick(5);
        in_a = 8'h01;
        tick(30);
        rd("t6_glitch_data", 2'd0, 32'h01, 1'b0);
        rd("t6_glitch_edge", 2'd3, 32'h0, 1'b0);
        in_a = 8'h03;
        tick(SYNC + DB - 1);
        rd("t6_data_before", 2'd0, 32'h01, 1'b0);
        rd("t6_data_after", 2'd0, 32'h03, 1'b0);
        tick(20);
        rd("t6_edge", 2'd3, 32'h02, 1'b0);
`endif

        tick(3);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
